// File: rtl/playback_pkg.sv
// Shared types and constants for the RAM playback scheduler.
package playback_pkg;

  // Playback sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WAIT,
    DONE
  } state_t;

  // Shortest sample period: one cycle to strobe, one cycle to capture.
  localparam int MIN_PERIOD      = 2;
  localparam int FRAME_CNT_WIDTH = 8;

endpackage

// File: rtl/sample_rate_divider.sv
// Down-counter that paces RAM reads.
// The count is loaded on the read strobe cycle, and o_tick marks the last
// cycle before the next read is due.
module sample_rate_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_period,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_count;

  // Reload on each strobe, then count down and hold at zero.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_period - DIV_WIDTH'(1);
    end else if (r_count != '0) begin
      r_count <= r_count - DIV_WIDTH'(1);
    end
  end

  // The cycle holding a count of 1 is P-1 cycles after the strobe.
  // Leaving the FSM on this cycle lands the next strobe exactly P cycles later.
  assign o_tick = (r_count == DIV_WIDTH'(1));

endmodule

// File: rtl/ram_playback_scheduler.sv
// Walks RAM addresses 0..last_addr at a programmable period.
// It issues one read strobe per sample, and presents each returned word as a sample.
// Reads are held off while the host write path is busy, and any such delay is flagged.
module ram_playback_scheduler
  import playback_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               stop,
  input  logic                               loop_en,
  input  logic [ADDR_WIDTH-1:0]              last_addr,
  input  logic [DIV_WIDTH-1:0]               sample_div,
  input  logic                               write_busy,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ram_data_in,
  output logic                               ram_read_en,
  output logic [ADDR_WIDTH-1:0]              ram_addr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_out,
  output logic                               sample_valid,
  output logic                               busy,
  output logic                               done,
  output logic [FRAME_CNT_WIDTH-1:0]         frame_count,
  output logic                               underrun
);

  state_t                             r_state;
  logic [ADDR_WIDTH-1:0]              r_addr;
  logic [ADDR_WIDTH-1:0]              r_last_addr;
  logic [DIV_WIDTH-1:0]               r_period;
  logic [FRAME_CNT_WIDTH-1:0]         r_frame_count;
  logic                               r_busy;
  logic                               r_done;
  logic                               r_underrun;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] r_sample;

  logic                               w_strobe;
  logic                               w_capture;
  logic                               w_tick;
  logic                               w_at_last;
  logic [DIV_WIDTH-1:0]               w_period;

  // A read issues in READ only when the host write path is idle.
  // The decision must be made within the cycle, so the strobe follows write_busy directly.
  assign w_strobe  = (r_state == READ) && !write_busy;
  // Returned data is live in CAPTURE. A stop in that cycle discards the sample.
  assign w_capture = (r_state == CAPTURE) && !stop;
  assign w_at_last = (r_addr == r_last_addr);
  assign w_period  = (sample_div < DIV_WIDTH'(MIN_PERIOD)) ? DIV_WIDTH'(MIN_PERIOD)
                                                           : sample_div;

  sample_rate_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_divider (
    .clk     (clk),
    .rst     (rst),
    .i_clear (stop),
    .i_load  (w_strobe),
    .i_period(r_period),
    .o_tick  (w_tick)
  );

  // Playback sequencer: run control, address walk, frame counter and sample hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_last_addr   <= '0;
      r_period      <= '0;
      r_frame_count <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_underrun    <= 1'b0;
      r_sample      <= '0;
    end else if (stop) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_last_addr   <= last_addr;
            r_period      <= w_period;
            r_addr        <= '0;
            r_frame_count <= '0;
            r_done        <= 1'b0;
            r_underrun    <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= READ;
          end
        end
        READ: begin
          if (write_busy) begin
            r_underrun <= 1'b1;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_sample <= ram_data_in;
          if (w_at_last && !loop_en) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            if (w_at_last) begin
              r_addr        <= '0;
              r_frame_count <= r_frame_count + FRAME_CNT_WIDTH'(1);
            end else begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            // At the minimum period there is no idle cycle, so WAIT is skipped.
            r_state <= w_tick ? READ : WAIT;
          end
        end
        WAIT: begin
          if (w_tick) begin
            r_state <= READ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_read_en  = w_strobe;
  assign ram_addr     = r_addr;
  assign sample_valid = w_capture;
  assign sample_out   = w_capture ? ram_data_in : r_sample;
  assign busy         = r_busy;
  assign done         = r_done;
  assign frame_count  = r_frame_count;
  assign underrun     = r_underrun;

endmodule

// File: doc/ram_playback_scheduler.md
Name: ram_playback_scheduler

Overview:
- Sequences reads from the wide sample RAM (NUM_CHANNELS x DATA_WIDTH words, 2^ADDR_WIDTH deep) at a programmable sample rate and streams each word to the processing system as one sample.
- Sits between the host byte-write path, the RAM read port and the processing-system input; replaces the raw read-enable pin with a timed address walk.
- Supports single-shot and looped playback, holds off while a host write is in progress, and flags late samples.

Parameters:
- NUM_CHANNELS, 4, channels per RAM word
- DATA_WIDTH, 16, bits per channel
- ADDR_WIDTH, 4, RAM address width
- DIV_WIDTH, 16, sample-period counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- start  in  1  begin playback (level, sampled each cycle)
- stop  in  1  abort playback; priority over start
- loop_en  in  1  1 = wrap to address 0 after last_addr
- last_addr  in  ADDR_WIDTH  final address of the frame
- sample_div  in  DIV_WIDTH  clk cycles between successive reads
- write_busy  in  1  host write buffer collecting or committing; reads must not issue
- ram_data_in  in  NUM_CHANNELS*DATA_WIDTH  RAM data_out; valid 1 cycle after ram_read_en
- ram_read_en  out  1  RAM read strobe, 1-cycle pulse
- ram_addr  out  ADDR_WIDTH  RAM read address
- sample_out  out  NUM_CHANNELS*DATA_WIDTH  captured sample; held between updates
- sample_valid  out  1  1-cycle pulse when sample_out updates
- busy  out  1  playback active
- done  out  1  single-shot frame complete; held until next start or stop
- frame_count  out  8  completed loop frames, wraps at 256
- underrun  out  1  sticky: a read was delayed by write_busy; cleared on start

Behaviour:
- Reset: every output 0, state IDLE, all internal counters 0.
- States: IDLE, READ, CAPTURE, WAIT, DONE.
- IDLE/DONE + start (stop=0) at edge T: latch last_addr, sample_div; addr=0; clear done, underrun, frame_count; busy=1 from T+1; go to READ.
- READ: ram_read_en=1 with ram_addr=current addr, unless write_busy=1. In that case stay in READ, keep ram_read_en=0, set underrun. Go to CAPTURE.
- CAPTURE: sample_out<=ram_data_in, sample_valid=1 for one cycle, so latency is read strobe to valid = 1 cycle.
  - If addr==latched last_addr and loop_en=0, go to DONE: busy=0, done=1.
  - If addr==latched last_addr and loop_en=1, addr<=0, frame_count+1, go to WAIT.
  - Otherwise addr+1, go to WAIT.
- Period: P = max(latched sample_div, 2). The divider starts counting on the READ strobe cycle. The next READ strobe comes exactly P cycles after the previous one when no stall occurs. A stall delays that read only; the next period is measured from the actual strobe, and no catch-up is attempted.
- loop_en is sampled live at each CAPTURE. last_addr and sample_div are latched and do not affect a run already in progress.
- stop=1 in any state: go to IDLE at the next edge; busy=0, done=0. An in-flight read is discarded, with no sample_valid. sample_out, frame_count and underrun are held.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- last_addr=0 gives a one-word frame. In loop mode it rereads address 0 every P cycles and increments frame_count on every sample.
- Asynchronous rst mid-run: immediate return to reset values; no pending strobe survives.

Decomposition:
- Shared package (playback_pkg):
  - state enum {IDLE, READ, CAPTURE, WAIT, DONE}
  - MIN_PERIOD=2
  - FRAME_CNT_WIDTH=8
- One sub-module: sample_rate_divider (load/clear, P-cycle down-counter, tick output). The FSM and address and frame counters stay in the top of the block.

Test Plan:
- sample_div=5, last_addr=3, loop_en=0, start pulse -> ram_read_en pulses at addr 0,1,2,3, exactly 5 cycles apart; sample_valid 1 cycle after each; done=1 and busy=0 after the 4th sample; no 5th read.
- loop_en=1, last_addr=2, sample_div=3, run 10 samples -> address sequence 0,1,2,0,1,2,0,1,2,0; frame_count=3; done stays 0.
- sample_div=0 or 1 -> reads every 2 cycles (P=2), no missed sample_valid.
- write_busy held high for 4 cycles across a due read -> read is delayed until the first cycle write_busy=0; underrun=1; next read follows P cycles later; underrun clears on the next start.
- stop asserted in the cycle ram_read_en=1 -> no sample_valid follows; state IDLE; busy=0; sample_out keeps its previous value. start and stop both held -> stays IDLE.
- rst pulsed mid-WAIT with frame_count=5 -> all outputs 0 immediately (before next clk edge); a start after release restarts at addr 0.
